fetch_sequencer: RTL

Drives the program counter register and fetches instructions from instruction memory for the custom processor. The block produces the next-PC value that the program counter latches, and waits for the registered, saturated PC to come back on its input. It then reads instruction memory through a request/acknowledge handshake and presents each instruction to decode through a valid/ready handshake. It handles branch redirects, saturation at the last program address, and halting after the last instruction.

---
 rtl/fetch_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the next-PC value, waits for the registered PC to
// catch up, reads instruction memory and hands each instruction to decode.
module fetch_sequencer #(
  parameter int PROG_VALUE = 3,
  parameter int WIDTH      = 3,
  parameter int INSTR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [WIDTH-1:0]   pc_next,
  input  logic [WIDTH-1:0]   pc_cur,
  output logic               mem_req,
  output logic [WIDTH-1:0]   mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_valid,
  input  logic [WIDTH-1:0]   br_target,
  output logic               halted
);

  typedef enum logic [1:0] {SYNC, FETCH, HOLD, HALT} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PROG_VALUE);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   fetch_pc, fetch_pc_nx;
  logic [WIDTH-1:0]   req_addr, req_addr_nx;
  logic [WIDTH-1:0]   instr_pc_q, instr_pc_nx;
  logic [INSTR_W-1:0] instr_q, instr_nx;
  logic               flush, flush_nx;

  // The program counter saturates at LAST, so anything beyond it could never be matched.
  function automatic logic [WIDTH-1:0] clamp_pc(input logic [WIDTH-1:0] v);
    return (v > LAST) ? LAST : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SYNC;
      fetch_pc   <= '0;
      req_addr   <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      flush      <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_pc   <= fetch_pc_nx;
      req_addr   <= req_addr_nx;
      instr_pc_q <= instr_pc_nx;
      instr_q    <= instr_nx;
      flush      <= flush_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    instr_pc_nx = instr_pc_q;
    instr_nx    = instr_q;
    flush_nx    = flush;

    case (state)
      SYNC: begin
        if (!br_valid && (pc_cur == fetch_pc)) begin
          req_addr_nx = fetch_pc;
          state_nx    = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          if (!flush && !br_valid) begin
            instr_nx    = mem_rdata;
            instr_pc_nx = req_addr;
            state_nx    = HOLD;
          end else begin
            flush_nx = 1'b0;
            state_nx = SYNC;
          end
        end else if (br_valid) begin
          // The request in flight must still complete; remember to drop its data.
          flush_nx = 1'b1;
        end
      end
      HOLD: begin
        if (br_valid) begin
          state_nx = SYNC;
        end else if (instr_ready) begin
          if (fetch_pc == LAST) begin
            state_nx = HALT;
          end else begin
            fetch_pc_nx = fetch_pc + WIDTH'(1);
            state_nx    = SYNC;
          end
        end
      end
      HALT: begin
        if (br_valid) state_nx = SYNC;
      end
    endcase

    // A redirect always wins over the sequential increment.
    if (br_valid) fetch_pc_nx = clamp_pc(br_target);
  end

  assign pc_next     = fetch_pc;
  assign mem_req     = (state == FETCH);
  assign mem_addr    = req_addr;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALT);

endmodule
